// File: rtl/bbqm_pkg.sv
// Shared definitions for the BBqM control sequencer: opcodes, state encoding
// and the opcode classifier used by both the fetch latch and the FSM.
package bbqm_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_JZ    = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP   = 3'd0,
    CL_ALU   = 3'd1,
    CL_LOAD  = 3'd2,
    CL_STORE = 3'd3,
    CL_JMP   = 3'd4,
    CL_JZ    = 3'd5,
    CL_HALT  = 3'd6,
    CL_ILL   = 3'd7
  } op_class_t;

  // Any set bit above the 4-bit opcode space makes the instruction illegal.
  function automatic op_class_t op_classify(input logic [3:0] op, input logic upper_nz);
    op_class_t cls;
    if (upper_nz) begin
      cls = CL_ILL;
    end else begin
      case (op)
        OP_NOP:                 cls = CL_NOP;
        OP_ADD, OP_SUB, OP_AND: cls = CL_ALU;
        OP_LOAD:                cls = CL_LOAD;
        OP_STORE:               cls = CL_STORE;
        OP_JMP:                 cls = CL_JMP;
        OP_JZ:                  cls = CL_JZ;
        OP_HALT:                cls = CL_HALT;
        default:                cls = CL_ILL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/bbqm_sequencer_if.sv
// Sequencer-to-datapath/memory signal bundle; the sequencer is the slave side.
interface bbqm_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 4
);
  logic              start;
  logic              instr_valid;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] jmp_target;
  logic              mem_ready;
  logic              zero_flag;
  logic [ADDR_W-1:0] pc;
  logic              fetch_req;
  logic              ir_load;
  logic              alu_en;
  logic              mem_rd;
  logic              mem_wr;
  logic              reg_we;
  logic              illegal;
  logic              halted;
  logic [2:0]        state;

  modport master (
    output start, instr_valid, opcode, jmp_target, mem_ready, zero_flag,
    input  pc, fetch_req, ir_load, alu_en, mem_rd, mem_wr, reg_we, illegal, halted, state
  );

  modport slave (
    input  start, instr_valid, opcode, jmp_target, mem_ready, zero_flag,
    output pc, fetch_req, ir_load, alu_en, mem_rd, mem_wr, reg_we, illegal, halted, state
  );
endinterface

// File: rtl/bbqm_sequencer_pc_counter.sv
// Program counter register with synchronous reset; load wins over increment.
module pc_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Increment wraps naturally at the register width.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= d;
    end else if (inc) begin
      q_r <= q_r + W'(1'b1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/bbqm_sequencer.sv
// BBqM multi-cycle control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, owns the PC and drives the datapath enables.
module bbqm_sequencer
  import bbqm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 4
) (
  input logic              clk,
  input logic              reset,
  bbqm_sequencer_if.slave  bus
);

  localparam int OPC_EXT_W = (OPC_W > 4) ? OPC_W : 4;

  state_t             state_r;
  logic [OPC_W-1:0]   opcode_r;
  logic [ADDR_W-1:0]  target_r;
  logic               fetch_req_r;
  logic               alu_en_r;
  logic               mem_rd_r;
  logic               mem_wr_r;
  logic               reg_we_r;
  logic               illegal_r;
  logic               halted_r;

  logic [OPC_EXT_W-1:0] op_ext_s;
  logic [OPC_EXT_W-1:0] in_ext_s;
  op_class_t            cls_s;
  op_class_t            in_cls_s;
  logic                 pc_inc_s;
  logic                 pc_load_s;
  logic [ADDR_W-1:0]    pc_s;

  assign op_ext_s = OPC_EXT_W'(opcode_r);
  assign in_ext_s = OPC_EXT_W'(bus.opcode);
  assign cls_s    = op_classify(op_ext_s[3:0], |(op_ext_s >> 3'd4));
  assign in_cls_s = op_classify(in_ext_s[3:0], |(in_ext_s >> 3'd4));

  // PC advance/jump strobes, asserted in the cycle an instruction retires.
  always_comb begin
    pc_inc_s  = 1'b0;
    pc_load_s = 1'b0;
    case (state_r)
      ST_DECODE: pc_inc_s = (cls_s == CL_ILL);
      ST_EXEC: begin
        case (cls_s)
          CL_NOP:  pc_inc_s = 1'b1;
          CL_JMP:  pc_load_s = 1'b1;
          CL_JZ: begin
            pc_load_s = bus.zero_flag;
            pc_inc_s  = ~bus.zero_flag;
          end
          default: pc_inc_s = 1'b0;
        endcase
      end
      ST_MEM:  pc_inc_s = bus.mem_ready && (cls_s == CL_STORE);
      ST_WB:   pc_inc_s = 1'b1;
      default: pc_inc_s = 1'b0;
    endcase
  end

  pc_counter #(.W(ADDR_W)) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc_s),
    .load  (pc_load_s),
    .d     (target_r),
    .q     (pc_s)
  );

  // State machine; each enable is registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      opcode_r    <= '0;
      target_r    <= '0;
      fetch_req_r <= 1'b0;
      alu_en_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      reg_we_r    <= 1'b0;
      illegal_r   <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      fetch_req_r <= 1'b0;
      alu_en_r    <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      reg_we_r    <= 1'b0;
      illegal_r   <= 1'b0;
      halted_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r     <= ST_FETCH;
            fetch_req_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (bus.instr_valid) begin
            opcode_r  <= bus.opcode;
            target_r  <= bus.jmp_target;
            state_r   <= ST_DECODE;
            illegal_r <= (in_cls_s == CL_ILL);
          end else begin
            state_r     <= ST_FETCH;
            fetch_req_r <= 1'b1;
          end
        end
        ST_DECODE: begin
          case (cls_s)
            CL_HALT: begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end
            CL_ILL: begin
              state_r     <= ST_FETCH;
              fetch_req_r <= 1'b1;
            end
            default: begin
              state_r  <= ST_EXEC;
              alu_en_r <= 1'b1;
            end
          endcase
        end
        ST_EXEC: begin
          case (cls_s)
            CL_ALU: begin
              state_r  <= ST_WB;
              reg_we_r <= 1'b1;
            end
            CL_LOAD: begin
              state_r  <= ST_MEM;
              mem_rd_r <= 1'b1;
            end
            CL_STORE: begin
              state_r  <= ST_MEM;
              mem_wr_r <= 1'b1;
            end
            default: begin
              state_r     <= ST_FETCH;
              fetch_req_r <= 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            if (cls_s == CL_LOAD) begin
              state_r  <= ST_WB;
              reg_we_r <= 1'b1;
            end else begin
              state_r     <= ST_FETCH;
              fetch_req_r <= 1'b1;
            end
          end else begin
            state_r  <= ST_MEM;
            mem_rd_r <= (cls_s == CL_LOAD);
            mem_wr_r <= (cls_s == CL_STORE);
          end
        end
        ST_WB: begin
          state_r     <= ST_FETCH;
          fetch_req_r <= 1'b1;
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pc        = pc_s;
  assign bus.fetch_req = fetch_req_r;
  assign bus.ir_load   = (state_r == ST_FETCH) && bus.instr_valid;
  assign bus.alu_en    = alu_en_r;
  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.reg_we    = reg_we_r;
  assign bus.illegal   = illegal_r;
  assign bus.halted    = halted_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_bbqm_sequencer.sv
// Scoreboard bench for bbqm_sequencer: an architectural model predicts per-instruction
// latency, enable counts and next PC; a negedge monitor retires and compares them.
module tb_bbqm_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bbqm_sequencer_if #(.ADDR_W(8), .OPC_W(4)) bus();
  bbqm_sequencer #(.ADDR_W(8), .OPC_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0] op;
    logic [7:0] tgt;
    bit         z;
    int         wait_c;
    int         delay;
  } instr_t;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] npc;
    int         lat;
    int         n_alu, n_rd, n_wr, n_we, n_ill;
    bit         halt;
  } exp_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  exp_t       sb_q[$];
  logic [7:0] m_pc;
  int         wait_cur = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [7:0] tgt, input bit z,
                                input int wait_c, input int delay);
    instr_t i;
    i.op = op; i.tgt = tgt; i.z = z; i.wait_c = wait_c; i.delay = delay;
    return i;
  endfunction

  // Architectural expectation for one instruction fetched at pc.
  function automatic exp_t model(input instr_t in, input logic [7:0] pc);
    exp_t e;
    e.pc = pc; e.npc = pc + 8'd1; e.lat = 3; e.n_alu = 1;
    e.n_rd = 0; e.n_wr = 0; e.n_we = 0; e.n_ill = 0; e.halt = 1'b0;
    case (in.op)
      4'd1, 4'd2, 4'd3: begin e.lat = 4; e.n_we = 1; end
      4'd4:  begin e.lat = 5 + in.wait_c; e.n_rd = in.wait_c + 1; e.n_we = 1; end
      4'd5:  begin e.lat = 4 + in.wait_c; e.n_wr = in.wait_c + 1; end
      4'd6:  e.npc = in.tgt;
      4'd7:  e.npc = in.z ? in.tgt : pc + 8'd1;
      4'd0:  e.lat = 3;
      4'd15: begin e.lat = 2; e.n_alu = 0; e.npc = pc; e.halt = 1'b1; end
      default: begin e.lat = 2; e.n_alu = 0; e.n_ill = 1; end
    endcase
    return e;
  endfunction

  // Wait for a fetch, record the expectation, then present the instruction.
  task automatic issue(input instr_t in);
    exp_t e;
    int g = 0;
    while (!bus.fetch_req && g < 300) begin
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.opcode      = 4'($urandom);
      @(posedge clk); #1;
      g++;
    end
    bus.instr_valid = 1'b0;
    if (!bus.fetch_req) begin
      check("fetch_timeout", 64'(bus.fetch_req), 64'(1));
    end else begin
      e = model(in, m_pc);
      sb_q.push_back(e);
      m_pc          = e.npc;
      bus.zero_flag = in.z;
      wait_cur      = in.wait_c;
      repeat (in.delay) begin @(posedge clk); #1; end
      bus.instr_valid = 1'b1;
      bus.opcode      = in.op;
      bus.jmp_target  = in.tgt;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      bus.opcode      = 4'($urandom);
      bus.jmp_target  = 8'($urandom);
    end
  endtask

  // Data memory: ready after wait_cur MEM cycles, random noise otherwise.
  initial begin
    int memcnt = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        memcnt = 0;
        bus.mem_ready = 1'b0;
      end else if (bus.mem_rd || bus.mem_wr) begin
        bus.mem_ready = (memcnt == wait_cur);
        memcnt++;
      end else begin
        memcnt = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: retire one expectation per ir_load and compare when FETCH/HALT is reached.
  initial begin
    exp_t cur;
    bit inflight = 1'b0;
    int k = 0, c_alu = 0, c_rd = 0, c_wr = 0, c_we = 0, c_ill = 0;
    int k_alu = -1, k_we = -1, k_mem = -1, k_ill = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight = 1'b0;
      end else begin
        check("mem_exclusive", 64'(bus.mem_rd & bus.mem_wr), 64'(0));
        if (inflight) begin
          k++;
          if (bus.halted || bus.fetch_req) begin
            check("latency", 64'(k), 64'(cur.lat));
            check("halted", 64'(bus.halted), 64'(cur.halt));
            check("pc_next", 64'(bus.pc), 64'(cur.npc));
            check("alu_en_count", 64'(c_alu), 64'(cur.n_alu));
            check("mem_rd_count", 64'(c_rd), 64'(cur.n_rd));
            check("mem_wr_count", 64'(c_wr), 64'(cur.n_wr));
            check("reg_we_count", 64'(c_we), 64'(cur.n_we));
            check("illegal_count", 64'(c_ill), 64'(cur.n_ill));
            if (cur.n_alu > 0) check("alu_en_cycle", 64'(k_alu), 64'(2));
            if (cur.n_we > 0) check("reg_we_cycle", 64'(k_we), 64'(cur.lat - 1));
            if (cur.n_rd + cur.n_wr > 0) check("mem_cycle", 64'(k_mem), 64'(3));
            if (cur.n_ill > 0) check("illegal_cycle", 64'(k_ill), 64'(1));
            inflight = 1'b0;
          end else begin
            if (bus.alu_en) begin c_alu++; k_alu = k; end
            if (bus.mem_rd) c_rd++;
            if (bus.mem_wr) c_wr++;
            if ((bus.mem_rd || bus.mem_wr) && k_mem < 0) k_mem = k;
            if (bus.reg_we) begin c_we++; k_we = k; end
            if (bus.illegal) begin c_ill++; k_ill = k; end
            if (k > 300) begin
              check("progress", 64'(k), 64'(cur.lat));
              inflight = 1'b0;
            end
          end
        end
        if (bus.ir_load) begin
          if (sb_q.size() == 0) begin
            check("unexpected_fetch", 64'(1), 64'(0));
          end else begin
            cur = sb_q.pop_front();
            check("pc_fetch", 64'(bus.pc), 64'(cur.pc));
            inflight = 1'b1;
            k = 0; c_alu = 0; c_rd = 0; c_wr = 0; c_we = 0; c_ill = 0;
            k_alu = -1; k_we = -1; k_mem = -1; k_ill = -1;
          end
        end
      end
    end
  end

  // Main sequence: reset, directed program, random program, halt, reset-in-MEM.
  initial begin
    instr_t prog[$];
    int g;
    reset = 1'b1;
    bus.start = 1'b0; bus.instr_valid = 1'b0; bus.opcode = 4'd0;
    bus.jmp_target = 8'd0; bus.zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'(bus.state), 64'(0));
    check("reset_pc", 64'(bus.pc), 64'(0));
    check("reset_outs", 64'({bus.fetch_req, bus.ir_load, bus.alu_en, bus.mem_rd, bus.mem_wr,
                             bus.reg_we, bus.illegal, bus.halted}), 64'(0));
    reset = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_state", 64'(bus.state), 64'(1));
    check("start_fetch_req", 64'(bus.fetch_req), 64'(1));
    check("start_pc", 64'(bus.pc), 64'(0));
    check("start_outs", 64'({bus.ir_load, bus.alu_en, bus.mem_rd, bus.mem_wr,
                             bus.reg_we, bus.illegal, bus.halted}), 64'(0));
    m_pc = 8'd0;

    prog.push_back(mk(4'd1, 8'h00, 1'b0, 0, 0));
    prog.push_back(mk(4'd4, 8'h00, 1'b0, 3, 0));
    prog.push_back(mk(4'd7, 8'h20, 1'b1, 0, 0));
    prog.push_back(mk(4'd6, 8'hFF, 1'b0, 0, 1));
    prog.push_back(mk(4'd7, 8'h33, 1'b0, 0, 0));
    prog.push_back(mk(4'd6, 8'h05, 1'b0, 0, 0));
    prog.push_back(mk(4'd5, 8'h00, 1'b0, 0, 2));
    prog.push_back(mk(4'd5, 8'h00, 1'b0, 2, 0));
    for (int i = 0; i < 60; i++)
      prog.push_back(mk(4'($urandom_range(0, 14)), 8'($urandom), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 2))));
    prog.push_back(mk(4'd9, 8'h00, 1'b0, 0, 0));
    prog.push_back(mk(4'd15, 8'h00, 1'b0, 0, 0));
    foreach (prog[i]) issue(prog[i]);

    g = 0;
    while (!bus.halted && g < 20) begin @(posedge clk); #1; g++; end
    for (int i = 0; i < 20; i++) begin
      bus.start = ~bus.start;
      @(posedge clk); #1;
      check("halt_sticky", 64'({bus.halted, bus.state}), 64'({1'b1, 3'd6}));
    end
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("halt_cleared", 64'({bus.halted, bus.state}), 64'(0));

    reset = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_pc = 8'd0;
    issue(mk(4'd0, 8'h00, 1'b0, 0, 0));
    issue(mk(4'd5, 8'h00, 1'b0, 10, 0));
    g = 0;
    while (!bus.mem_wr && g < 50) begin @(posedge clk); #1; g++; end
    check("mem_wr_reached", 64'(bus.mem_wr), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mem_wr", 64'(bus.mem_wr), 64'(0));
    check("rst_mem_state", 64'(bus.state), 64'(0));
    check("rst_mem_pc", 64'(bus.pc), 64'(0));
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", 64'(bus.state), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bbqm_sequencer.md
# bbqm_sequencer

Multi-cycle control sequencer for the BBqM CPU. It walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB, and owns the program counter. It generates the load and write enables consumed by the datapath register flip-flops, the ALU and the memory port. It sits directly upstream of the datapath storage elements: its `reg_we`, `ir_load` and `pc` outputs feed their D and enable inputs.

## Interface
- `ADDR_W`, default 8: program counter and jump target width.
- `OPC_W`, default 4: opcode width.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: leave IDLE and begin fetching at `pc`=0. Sampled in IDLE only.
- `instr_valid` in 1: instruction memory has `opcode`/`jmp_target` valid this cycle.
- `opcode` in OPC_W: opcode field of the fetched instruction.
- `jmp_target` in ADDR_W: operand field, used as the branch target.
- `mem_ready` in 1: data memory completed the current read or write.
- `zero_flag` in 1: ALU zero flag.
- `pc` out ADDR_W: current program counter.
- `fetch_req` out 1: instruction fetch request.
- `ir_load` out 1: instruction register load enable.
- `alu_en` out 1: ALU operate enable.
- `mem_rd` out 1: data memory read.
- `mem_wr` out 1: data memory write.
- `reg_we` out 1: register file write enable.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `halted` out 1: sequencer is stopped.
- `state` out 3: current state encoding, for debug.

## Operation
- **Opcodes:**
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND (the ALU ops)
  - 4 LOAD, 5 STORE
  - 6 JMP, 7 JZ
  - 15 HALT
  - All other opcodes are illegal and are executed as NOP with an `illegal` pulse.
- **Opcode latch:** `opcode` and `jmp_target` are latched internally on the FETCH cycle where `instr_valid`=1. Later states use only the latched copies.
- **States and transitions:**
  - IDLE → FETCH when `start`=1.
  - FETCH: `fetch_req`=1. If `instr_valid`=1, `ir_load`=1 in that same cycle and next state is DECODE; otherwise stay in FETCH.
  - DECODE (1 cycle):
    - HALT → HALT.
    - Illegal → assert `illegal`, `pc`←`pc`+1, → FETCH.
    - All other opcodes → EXEC.
  - EXEC (1 cycle, `alu_en`=1):
    - ALU op → WB.
    - LOAD/STORE → MEM.
    - JMP → `pc`←`jmp_target`, → FETCH.
    - JZ → `pc`←`jmp_target` if `zero_flag`=1, else `pc`+1, → FETCH.
    - NOP → `pc`+1, → FETCH.
  - MEM: `mem_rd` (LOAD) or `mem_wr` (STORE) held high until `mem_ready`=1.
    - LOAD → WB.
    - STORE → `pc`+1, → FETCH.
  - WB (1 cycle): `reg_we`=1, `pc`←`pc`+1, → FETCH.
  - HALT: `halted`=1. Sticky until `reset`; `start` is ignored.
- **PC arithmetic:** `pc`+1 wraps modulo 2^ADDR_W (all-ones → 0).
- **start outside IDLE:** `start` is ignored in every state other than IDLE.
- **Output decode:** all enables are decoded from the state register, except `ir_load`, which is FETCH AND `instr_valid`. At most one of `mem_rd`/`mem_wr` is high in any cycle.

## Timing
- **Reset:** state=IDLE, `pc`=0, latched opcode=0, and every output is 0 (including `halted`, `illegal` and `state`=0) from the first edge with `reset`=1.
- **Reset mid-operation:** reset has priority in any state, including MEM with a request outstanding. The request drops on the next edge.
- **Instruction latency, measured from FETCH entry with `instr_valid` immediately high:**
  - ALU op: 4 cycles.
  - LOAD: 5 cycles plus memory wait cycles.
  - STORE: 4 cycles plus memory wait cycles.
  - JMP, JZ, NOP: 3 cycles.
  - Illegal opcode: 2 cycles.
- **PC update:** `pc` changes on the edge leaving WB, EXEC, MEM or DECODE, as specified above. It is stable throughout FETCH.
- **Sampling points:**
  - `zero_flag` is sampled only in the EXEC cycle.
  - `mem_ready` is sampled only in MEM; if it is high on the first MEM cycle, MEM lasts exactly 1 cycle.
  - `instr_valid` is ignored outside FETCH.

## Structure
- Package `bbqm_pkg` holds:
  - Opcode localparams (OP_NOP…OP_HALT).
  - State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- One sub-module, `pc_counter`: ADDR_W register with synchronous reset, `inc` and `load` inputs. `load` has priority over `inc`.
- The FSM and output decode stay in `bbqm_sequencer`.

## Test plan
- **Reset and start:** `reset` 2 cycles, then `start`=1 → `state`=1, `fetch_req`=1, `pc`=0; all other outputs 0.
- **ADD with instant `instr_valid`:** opcode 1 → `ir_load` at cycle 0, `alu_en` at cycle 2, `reg_we` at cycle 3; `pc`=1 at cycle 4 in FETCH.
- **LOAD with `mem_ready` delayed 3 cycles:** `mem_rd` high for 4 cycles, then `reg_we` for 1 cycle; `mem_wr` never asserts; `pc` advances by 1.
- **Branches:** JZ with target 0x20 and `zero_flag`=1 → `pc`=0x20. JZ with `zero_flag`=0 at `pc`=0xFF → `pc`=0x00 (wrap). JMP to 0x05 → `pc`=0x05.
- **Illegal then HALT:** opcode 9 → one `illegal` pulse and `pc`+1. Next fetch opcode 15 → `halted`=1 held for 20 cycles with `start` toggling; `reset` clears it.
- **Reset during MEM:** `reset` asserted while `mem_wr`=1 → next cycle `mem_wr`=0, `state`=0, `pc`=0.
